// File: rtl/csa_resolve_if.sv
// Operand/result channel bundle for csa_resolve: carry-save pair in, binary result out.
// Both directions use valid/ready; the master side is the producer/consumer, the slave side is the resolver.
interface csa_resolve_if #(
  parameter int WIDTH = 64
);
  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] sum_dat;
  logic [WIDTH-1:0] carry_dat;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] result_dat;
  logic             overflow_dat;

  modport master (
    output in_vld, sum_dat, carry_dat, out_rdy,
    input  in_rdy, out_vld, result_dat, overflow_dat
  );

  modport slave (
    input  in_vld, sum_dat, carry_dat, out_rdy,
    output in_rdy, out_vld, result_dat, overflow_dat
  );
endinterface

// File: rtl/csa_resolve.sv
// Resolves a carry-save pair to binary one CHUNK slice per cycle: result valid N=WIDTH/CHUNK edges after accept.
// Holds the result until out_rdy; no new operand is taken until the result has been consumed.
module csa_resolve #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  csa_resolve_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] car_q;
  logic [WIDTH-1:0] res_q;
  logic [IW-1:0]    idx_q;
  logic             cy_q;
  logic             ovf_pend_q;
  logic             ovf_q;
  logic             out_vld_q;

  logic [CHUNK:0]   chunk_d;
  logic             last_chunk;

  // One short CHUNK-bit ripple per cycle; the carry-out chains into the next slice via cy_q.
  assign chunk_d = {1'b0, sum_q[idx_q*CHUNK +: CHUNK]}
                 + {1'b0, car_q[idx_q*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, cy_q};

  assign last_chunk = (idx_q == IW'(N - 1));

  assign bus.in_rdy       = (state_q == IDLE) & ~flush_i;
  assign bus.out_vld      = out_vld_q;
  assign bus.result_dat   = res_q;
  assign bus.overflow_dat = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      car_q      <= '0;
      res_q      <= '0;
      idx_q      <= '0;
      cy_q       <= 1'b0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      out_vld_q  <= 1'b0;
    end else if (flush_i) begin
      state_q   <= IDLE;
      res_q     <= '0;
      idx_q     <= '0;
      cy_q      <= 1'b0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_vld) begin
            sum_q      <= bus.sum_dat;
            // Carry vector carries weight 2^(i+1); its top bit falls off the result and only feeds overflow.
            car_q      <= {bus.carry_dat[WIDTH-2:0], 1'b0};
            ovf_pend_q <= bus.carry_dat[WIDTH-1];
            res_q      <= '0;
            idx_q      <= '0;
            cy_q       <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          res_q[idx_q*CHUNK +: CHUNK] <= chunk_d[CHUNK-1:0];
          cy_q                        <= chunk_d[CHUNK];
          idx_q                       <= idx_q + 1'b1;
          if (last_chunk) begin
            ovf_q     <= chunk_d[CHUNK] | ovf_pend_q;
            out_vld_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (bus.out_rdy) begin
            out_vld_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_resolve.sv
// Scoreboard bench for csa_resolve: directed cases plus randomized traffic with gaps, backpressure and flushes.
module tb_csa_resolve;

  typedef struct {
    logic [63:0] res;
    logic        ovf;
  } exp_t;

  localparam int NRAND = 4000;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  csa_resolve_if #(.WIDTH(64)) bus ();

  csa_resolve #(.WIDTH(64), .CHUNK(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  function automatic exp_t model(input logic [63:0] s, input logic [63:0] c);
    logic [65:0] t;
    exp_t        e;
    t     = {2'b00, s} + ({2'b00, c} << 1);
    e.res = t[63:0];
    e.ovf = |t[65:64];
    return e;
  endfunction

  function automatic exp_t mk(input logic [63:0] r, input logic o);
    exp_t e;
    e.res = r;
    e.ovf = o;
    return e;
  endfunction

  function automatic logic [63:0] rnd64(input int sel);
    logic [63:0] v;
    v = {$urandom, $urandom};
    case (sel)
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = v | 64'h8000_0000_0000_0000;
      3:       v = v & 64'h0000_0000_0000_FFFF;
      default: v = v;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tmo(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired, got no event, expected one", name);
  endtask

  task automatic send(input logic [63:0] s, input logic [63:0] c, input exp_t e);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      bus.in_vld    = 1'b1;
      bus.sum_dat   = s;
      bus.carry_dat = c;
      #1;
      if (bus.in_rdy) begin
        exp_q.push_back(e);
        ok = 1'b1;
      end
    end
    if (!ok) tmo("send_accept");
  endtask

  task automatic release_in();
    @(negedge clk);
    bus.in_vld = 1'b0;
  endtask

  task automatic wait_out_vld();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      #1;
      seen = bus.out_vld;
    end
    if (!seen) tmo("wait_out_vld");
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(negedge clk);
    #3;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every cycle a result is presented it must match the oldest expected entry; pop on handshake.
  always @(negedge clk) begin
    #2;
    if (!rst && !flush && bus.out_vld) begin
      if (exp_q.size() == 0) begin
        tmo("spurious_out_vld");
      end else begin
        chk("result", bus.result_dat, exp_q[0].res);
        chk("overflow", 64'(bus.overflow_dat), 64'(exp_q[0].ovf));
        chk("in_rdy_while_done", 64'(bus.in_rdy), 64'd0);
        if (bus.out_rdy) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_vld    = 1'b1;
    bus.sum_dat   = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.carry_dat = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.out_rdy   = 1'b1;

    // Reset held with valid input: nothing accepted, outputs at reset values.
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_in_rdy", 64'(bus.in_rdy), 64'd1);
      chk("rst_out_vld", 64'(bus.out_vld), 64'd0);
      chk("rst_result", bus.result_dat, 64'd0);
      chk("rst_overflow", 64'(bus.overflow_dat), 64'd0);
    end
    @(negedge clk);
    bus.in_vld = 1'b0;
    rst        = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("no_accept_in_reset", 64'(bus.out_vld), 64'd0);

    // Cross-chunk carry with latency profile.
    send(64'h0000_0000_FFFF_FFFF, 64'h1, mk(64'h0000_0001_0000_0001, 1'b0));
    @(negedge clk);
    bus.in_vld = 1'b0;
    #1;
    chk("in_rdy_after_accept", 64'(bus.in_rdy), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("out_vld_early", 64'(bus.out_vld), 64'd0);
    @(negedge clk);
    #1;
    chk("out_vld_on_time", 64'(bus.out_vld), 64'd1);
    @(negedge clk);
    #3;
    chk("out_vld_drop", 64'(bus.out_vld), 64'd0);
    chk("in_rdy_back", 64'(bus.in_rdy), 64'd1);

    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, mk(64'h1, 1'b1));
    release_in();
    wait_drain("drain_ovf_a");
    send(64'h0, 64'h8000_0000_0000_0000, mk(64'h0, 1'b1));
    release_in();
    wait_drain("drain_ovf_b");

    // Backpressure: result held for 5 cycles, then released.
    bus.out_rdy = 1'b0;
    send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, mk(64'h2345_6789_ABCD_F011, 1'b0));
    release_in();
    wait_out_vld();
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("bp_out_vld", 64'(bus.out_vld), 64'd1);
      chk("bp_in_rdy", 64'(bus.in_rdy), 64'd0);
    end
    @(negedge clk);
    bus.out_rdy = 1'b1;
    @(negedge clk);
    #3;
    chk("bp_out_vld_drop", 64'(bus.out_vld), 64'd0);
    chk("bp_in_rdy_back", 64'(bus.in_rdy), 64'd1);

    // Flush after two resolve edges: the result must never appear.
    send(64'hDEAD_BEEF_0000_1234, 64'h0000_0000_1111_0001, mk(64'h0, 1'b0));
    release_in();
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    exp_q.delete();
    #1;
    chk("flush_in_rdy_low", 64'(bus.in_rdy), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_in_rdy", 64'(bus.in_rdy), 64'd1);
    repeat (6) begin
      @(negedge clk);
      #1;
      chk("flush_no_out", 64'(bus.out_vld), 64'd0);
    end

    // Asynchronous reset mid-operation, checked before any clock edge.
    send(64'h1111_1111_1111_1111, 64'h0, mk(64'h1111_1111_1111_1111, 1'b0));
    release_in();
    @(negedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_result", bus.result_dat, 64'd0);
    chk("arst_overflow", 64'(bus.overflow_dat), 64'd0);
    chk("arst_out_vld", 64'(bus.out_vld), 64'd0);
    chk("arst_in_rdy", 64'(bus.in_rdy), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    send(64'd5, 64'd3, mk(64'd11, 1'b0));
    release_in();
    wait_drain("drain_5_3");

    // Random traffic with gaps, backpressure and occasional flushes.
    for (int op = 0; op < NRAND; op++) begin
      logic [63:0] s;
      logic [63:0] c;
      bit          acc;
      int          tries;
      s = rnd64(int'($urandom_range(0, 3)));
      c = rnd64(int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bus.out_rdy = ($urandom_range(0, 3) != 0);
      end
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 60) begin
        @(negedge clk);
        bus.out_rdy   = ($urandom_range(0, 3) != 0);
        bus.in_vld    = 1'b1;
        bus.sum_dat   = s;
        bus.carry_dat = c;
        flush         = ($urandom_range(0, 63) == 0);
        if (flush) exp_q.delete();
        #1;
        if (bus.in_rdy) begin
          exp_q.push_back(model(s, c));
          acc = 1'b1;
        end
        tries++;
      end
      if (!acc) tmo("rand_accept");
      @(negedge clk);
      bus.in_vld  = 1'b0;
      flush       = 1'b0;
      bus.out_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(0, 5)) begin
          @(negedge clk);
          bus.out_rdy = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        flush = 1'b0;
      end
    end

    @(negedge clk);
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    flush       = 1'b0;
    wait_drain("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
